// File: rtl/usb_tx_crc16_append_if.sv
// Handshake bundle between the TX data FIFO, the CRC16 append stage and the serializer.
// master drives packet control and payload; slave is the CRC stage.
interface usb_tx_crc16_append_if;
    logic       start;
    logic       zlp;
    logic       abort;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    logic       overflow;

    modport master (
        output start, zlp, abort, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, overflow
    );

    modport slave (
        input  start, zlp, abort, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, overflow
    );
endinterface

// File: rtl/usb_tx_crc16_append.sv
// Transmit-side USB CRC16 stage: forwards payload bytes through one register and
// appends the inverted CRC16 (low byte first) after the last byte.
module usb_tx_crc16_append #(
    parameter int MAX_BYTES = 64
) (
    input  logic                  clk,
    input  logic                  n_rst,
    usb_tx_crc16_append_if.slave  bus
);
    localparam int CW = $clog2(MAX_BYTES + 1);

    typedef enum logic [2:0] {IDLE, DATA, CRC_LO, CRC_HI, DRAIN} state_t;

    state_t          state;
    logic [15:0]     crc;
    logic [CW-1:0]   count;
    logic            vld;
    logic [7:0]      data;
    logic            last;
    logic            ovf;
    logic            hold_free;
    logic            accept;

    // Reflected CRC-16/USB, one byte processed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign hold_free     = !vld || bus.out_ready;
    assign bus.in_ready  = (state == DATA) && hold_free;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = vld;
    assign bus.out_data  = data;
    assign bus.out_last  = last;
    assign bus.overflow  = ovf;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            crc   <= 16'hFFFF;
            count <= '0;
            vld   <= 1'b0;
            data  <= 8'h00;
            last  <= 1'b0;
            ovf   <= 1'b0;
        end else if (bus.abort) begin
            state <= IDLE;
            vld   <= 1'b0;
            last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        crc   <= 16'hFFFF;
                        count <= '0;
                        ovf   <= 1'b0;
                        state <= bus.zlp ? CRC_LO : DATA;
                    end
                end
                DATA: begin
                    if (vld && bus.out_ready) vld <= 1'b0;
                    if (accept) begin
                        data  <= bus.in_data;
                        vld   <= 1'b1;
                        last  <= 1'b0;
                        crc   <= crc16_byte(crc, bus.in_data);
                        count <= count + CW'(1);
                        // The MAX_BYTES-th byte closes the payload even without in_last.
                        if (bus.in_last || count == CW'(MAX_BYTES - 1)) state <= CRC_LO;
                        if (!bus.in_last && count == CW'(MAX_BYTES - 1)) ovf <= 1'b1;
                    end
                end
                CRC_LO: begin
                    if (hold_free) begin
                        data  <= ~crc[7:0];
                        vld   <= 1'b1;
                        last  <= 1'b0;
                        state <= CRC_HI;
                    end
                end
                CRC_HI: begin
                    if (hold_free) begin
                        data  <= ~crc[15:8];
                        vld   <= 1'b1;
                        last  <= 1'b1;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (vld && bus.out_ready) begin
                        vld   <= 1'b0;
                        last  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
